uart_cmd_decoder: RTL and testbench
===================================

# uart_cmd_decoder

Byte-level command decoder sitting directly downstream of the UART receiver's parallel output. It assembles received bytes into write/read command frames, drives a single-port register-file interface, and returns read data as one byte to the UART transmitter's parallel input. Malformed frames, stray bytes and stalled frames are flagged on a one-cycle error pulse.

## Interface
- DATA_WIDTH, 8, byte width of RX/TX/register data
- ADDR_WIDTH, 4, register-file address width (must be ≤ DATA_WIDTH)
- TIMEOUT, 1024, idle cycles tolerated inside a frame before abort (≥ 2)

Ports:
- CLK  in  1  single clock; all logic on rising edge
- RST  in  1  synchronous, active-high reset
- RX_P_DATA  in  DATA_WIDTH  received byte
- RX_D_VLD  in  1  one-cycle pulse per received byte
- RF_RD_DATA  in  DATA_WIDTH  register-file read data
- RF_RD_DATA_VLD  in  1  RF_RD_DATA valid, one-cycle pulse
- TX_BUSY  in  1  transmitter busy
- RF_ADDR  out  ADDR_WIDTH  register address
- RF_WR_EN  out  1  write strobe, one cycle
- RF_RD_EN  out  1  read strobe, one cycle
- RF_WR_DATA  out  DATA_WIDTH  write data
- TX_P_DATA  out  DATA_WIDTH  byte to transmit
- TX_D_VLD  out  1  one-cycle transmit request
- FRAME_ERR  out  1  one-cycle error pulse

## Operation
- Frames: write = 0xAA, ADDR, DATA; read = 0xBB, ADDR → one reply byte.
- States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, TX_SEND.
- IDLE: byte 0xAA → WR_ADDR; 0xBB → RD_ADDR; any other byte → FRAME_ERR, stay IDLE.
- WR_ADDR / RD_ADDR: byte with any bit above ADDR_WIDTH-1 set → FRAME_ERR, IDLE. Otherwise latch RF_ADDR, then go to WR_DATA (write) or issue RF_RD_EN and go to RD_WAIT (read).
- WR_DATA: byte latched to RF_WR_DATA, RF_WR_EN pulsed, → IDLE.
- RD_WAIT: RF_RD_DATA_VLD → capture RF_RD_DATA into TX_P_DATA, → TX_SEND.
- TX_SEND: when TX_BUSY=0, pulse TX_D_VLD, → IDLE. While TX_BUSY=1, hold.
- RX_D_VLD in RD_WAIT or TX_SEND: byte dropped, FRAME_ERR pulsed, state unchanged.
- Timeout: a counter clears on state entry and on every accepted byte, and runs in WR_ADDR, WR_DATA, RD_ADDR and RD_WAIT. After TIMEOUT consecutive cycles with no RX_D_VLD (RD_WAIT: no RF_RD_DATA_VLD), pulse FRAME_ERR and go to IDLE. No RF strobe is issued for an aborted frame. TX_SEND never times out.
- Counter width is $clog2(TIMEOUT+1); it saturates and never wraps.
- Only one frame is in flight; there is no input buffering.

## Timing
- Reset: state IDLE, counter 0. Every output is 0, including RF_ADDR, RF_WR_DATA and TX_P_DATA.
- Reset during a frame aborts it with no strobe and no error pulse.
- Outputs are registered. RF_WR_EN rises the cycle after the DATA byte's RX_D_VLD. RF_RD_EN rises the cycle after the ADDR byte's RX_D_VLD.
- RF_ADDR and RF_WR_DATA are valid during the strobe cycle and hold until the next frame overwrites them.
- RF_RD_DATA_VLD is accepted from the cycle after RF_RD_EN onward. A pulse coincident with RF_RD_EN, or arriving outside RD_WAIT, is ignored.
- TX_D_VLD rises at the earliest one cycle after capture, in any cycle where TX_BUSY=0 is sampled in TX_SEND. TX_P_DATA holds until the next capture.
- Best-case read latency: ADDR byte → RF_RD_EN 1 cycle → data (≥1 cycle) → TX_D_VLD 1 cycle.
- FRAME_ERR is asserted for exactly one cycle per event, registered one cycle after the cause.
- If RX_D_VLD coincides with the timeout cycle, the byte wins and no error is raised.
- Back-to-back frames: a 0xAA/0xBB arriving in the cycle IDLE is re-entered is accepted.

## Test plan
- Reset, then bytes 0xAA, 0x05, 0x3C → one RF_WR_EN pulse with RF_ADDR=5 and RF_WR_DATA=0x3C; FRAME_ERR stays 0; all outputs were 0 after reset.
- Bytes 0xBB, 0x0F; RF_RD_DATA=0x5A returned 3 cycles after RF_RD_EN, TX_BUSY=1 for 10 more cycles → RF_RD_EN once with RF_ADDR=0xF; TX_D_VLD pulses once, the cycle after TX_BUSY falls, with TX_P_DATA=0x5A.
- Byte 0x11 in IDLE; then 0xAA, 0x20 → two FRAME_ERR pulses; no RF strobe; ends in IDLE.
- TIMEOUT=16: byte 0xAA, then silence → FRAME_ERR exactly 16 cycles after 0xAA accepted; a later 0xAA, 0x02, 0x77 writes normally.
- Bytes 0xBB, 0x03, then 0x99 during RD_WAIT → FRAME_ERR; the reply still goes out with the correct data.
- RST asserted between ADDR and DATA of a write → no RF_WR_EN, no FRAME_ERR; the next full write succeeds.

Source files
------------

// File: rtl/uart_cmd_decoder_if.sv
// -----------------------------------------------------------------------------
// uart_cmd_decoder_if
//
// Groups every data/handshake signal around the UART command decoder:
//   RX side  : RX_P_DATA, RX_D_VLD                    (from UART receiver)
//   RF side  : RF_ADDR, RF_WR_EN, RF_RD_EN, RF_WR_DATA (to register file)
//              RF_RD_DATA, RF_RD_DATA_VLD              (from register file)
//   TX side  : TX_P_DATA, TX_D_VLD                     (to UART transmitter)
//              TX_BUSY                                 (from UART transmitter)
//   Status   : FRAME_ERR                               (one-cycle error pulse)
//
// modport master : the decoder itself (drives RF/TX requests and FRAME_ERR)
// modport slave  : the surrounding RX/RF/TX environment
// -----------------------------------------------------------------------------
interface uart_cmd_decoder_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    logic [DATA_WIDTH-1:0] RX_P_DATA;
    logic                  RX_D_VLD;
    logic [DATA_WIDTH-1:0] RF_RD_DATA;
    logic                  RF_RD_DATA_VLD;
    logic                  TX_BUSY;
    logic [ADDR_WIDTH-1:0] RF_ADDR;
    logic                  RF_WR_EN;
    logic                  RF_RD_EN;
    logic [DATA_WIDTH-1:0] RF_WR_DATA;
    logic [DATA_WIDTH-1:0] TX_P_DATA;
    logic                  TX_D_VLD;
    logic                  FRAME_ERR;

    modport master (
        input  RX_P_DATA, RX_D_VLD, RF_RD_DATA, RF_RD_DATA_VLD, TX_BUSY,
        output RF_ADDR, RF_WR_EN, RF_RD_EN, RF_WR_DATA, TX_P_DATA, TX_D_VLD,
               FRAME_ERR
    );

    modport slave (
        output RX_P_DATA, RX_D_VLD, RF_RD_DATA, RF_RD_DATA_VLD, TX_BUSY,
        input  RF_ADDR, RF_WR_EN, RF_RD_EN, RF_WR_DATA, TX_P_DATA, TX_D_VLD,
               FRAME_ERR
    );
endinterface

// File: rtl/uart_cmd_decoder.sv
// -----------------------------------------------------------------------------
// uart_cmd_decoder
//
// Assembles bytes from a UART receiver into register-file commands:
//   write frame : 0xAA, ADDR, DATA  -> one RF_WR_EN strobe
//   read frame  : 0xBB, ADDR        -> one RF_RD_EN strobe, then the returned
//                                      RF_RD_DATA is sent as one TX byte
// Unknown command bytes, out-of-range addresses, bytes arriving while a read
// reply is pending, and frames that stall for TIMEOUT cycles each produce a
// one-cycle FRAME_ERR pulse. All outputs are registered.
//
// Ports:
//   CLK  : clock, rising edge
//   RST  : synchronous, active-high reset
//   bus  : uart_cmd_decoder_if.master (RX input, RF request/response, TX
//          request/busy, FRAME_ERR)
//
// Parameters:
//   DATA_WIDTH : byte width of RX/TX/register data
//   ADDR_WIDTH : register address width (<= DATA_WIDTH)
//   TIMEOUT    : idle cycles tolerated inside a frame before abort (>= 2)
// -----------------------------------------------------------------------------
module uart_cmd_decoder #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int TIMEOUT    = 1024
) (
    input  logic                  CLK,
    input  logic                  RST,
    uart_cmd_decoder_if.master    bus
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [DATA_WIDTH-1:0] CMD_WR = DATA_WIDTH'(8'hAA);
    localparam logic [DATA_WIDTH-1:0] CMD_RD = DATA_WIDTH'(8'hBB);

    // The counter value seen on the last tolerated idle cycle; an idle cycle
    // observed with this value is the TIMEOUT-th one and aborts the frame.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR,
        WR_DATA,
        RD_ADDR,
        RD_WAIT,
        TX_SEND
    } state_t;

    state_t                state_q,      state_d;
    logic [CNT_W-1:0]      cnt_q,        cnt_d;
    logic [ADDR_WIDTH-1:0] rf_addr_q,    rf_addr_d;
    logic [DATA_WIDTH-1:0] rf_wr_data_q, rf_wr_data_d;
    logic [DATA_WIDTH-1:0] tx_p_data_q,  tx_p_data_d;
    logic                  rf_wr_en_q,   rf_wr_en_d;
    logic                  rf_rd_en_q,   rf_rd_en_d;
    logic                  tx_d_vld_q,   tx_d_vld_d;
    logic                  frame_err_q,  frame_err_d;

    logic                  rx_vld;
    logic [DATA_WIDTH-1:0] rx_byte;
    logic                  addr_bad;
    logic                  timed_out;
    logic [CNT_W-1:0]      cnt_inc;
    logic                  rd_data_ok;

    assign rx_vld  = bus.RX_D_VLD;
    assign rx_byte = bus.RX_P_DATA;

    // Any bit above the address field makes the byte an illegal address.
    // A shift keeps this valid even when ADDR_WIDTH == DATA_WIDTH.
    assign addr_bad = (rx_byte >> ADDR_WIDTH) != '0;

    assign timed_out = (cnt_q >= CNT_LAST);

    // Saturating increment: the counter must never wrap back to zero.
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

    // Read data is only taken from the cycle after the RF_RD_EN strobe; a
    // pulse coincident with the strobe cannot be an answer to it.
    assign rd_data_ok = bus.RF_RD_DATA_VLD && !rf_rd_en_q;

    always_comb begin
        // NOTE: every *_d gets a default before the case so no path leaves a
        // variable unassigned, which would otherwise infer a latch.
        state_d      = state_q;
        cnt_d        = cnt_q;
        rf_addr_d    = rf_addr_q;
        rf_wr_data_d = rf_wr_data_q;
        tx_p_data_d  = tx_p_data_q;
        rf_wr_en_d   = 1'b0;
        rf_rd_en_d   = 1'b0;
        tx_d_vld_d   = 1'b0;
        frame_err_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (rx_vld) begin
                    if (rx_byte == CMD_WR) begin
                        state_d = WR_ADDR;
                    end else if (rx_byte == CMD_RD) begin
                        state_d = RD_ADDR;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end

            WR_ADDR, RD_ADDR: begin
                cnt_d = cnt_inc;
                // A byte arriving on the timeout cycle takes precedence.
                if (rx_vld) begin
                    if (addr_bad) begin
                        frame_err_d = 1'b1;
                        state_d     = IDLE;
                    end else begin
                        rf_addr_d = rx_byte[ADDR_WIDTH-1:0];
                        if (state_q == WR_ADDR) begin
                            state_d = WR_DATA;
                        end else begin
                            rf_rd_en_d = 1'b1;
                            state_d    = RD_WAIT;
                        end
                    end
                end else if (timed_out) begin
                    frame_err_d = 1'b1;
                    state_d     = IDLE;
                end
            end

            WR_DATA: begin
                cnt_d = cnt_inc;
                if (rx_vld) begin
                    rf_wr_data_d = rx_byte;
                    rf_wr_en_d   = 1'b1;
                    state_d      = IDLE;
                end else if (timed_out) begin
                    frame_err_d = 1'b1;
                    state_d     = IDLE;
                end
            end

            RD_WAIT: begin
                cnt_d = cnt_inc;
                // Stray RX bytes are dropped but do not disturb the read.
                if (rx_vld) begin
                    frame_err_d = 1'b1;
                end
                if (rd_data_ok) begin
                    tx_p_data_d = bus.RF_RD_DATA;
                    state_d     = TX_SEND;
                end else if (timed_out) begin
                    frame_err_d = 1'b1;
                    state_d     = IDLE;
                end
            end

            TX_SEND: begin
                // Waiting on the transmitter is unbounded by design.
                cnt_d = '0;
                if (rx_vld) begin
                    frame_err_d = 1'b1;
                end
                if (!bus.TX_BUSY) begin
                    tx_d_vld_d = 1'b1;
                    state_d    = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Every accepted byte moves the FSM to a new state, so clearing on
        // state change covers both "state entry" and "accepted byte".
        if (state_d != state_q) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            // NOTE: the datapath registers (address, write data, reply byte)
            // are reset too, so every output reads 0 straight out of reset.
            state_q      <= IDLE;
            cnt_q        <= '0;
            rf_addr_q    <= '0;
            rf_wr_data_q <= '0;
            tx_p_data_q  <= '0;
            rf_wr_en_q   <= 1'b0;
            rf_rd_en_q   <= 1'b0;
            tx_d_vld_q   <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rf_addr_q    <= rf_addr_d;
            rf_wr_data_q <= rf_wr_data_d;
            tx_p_data_q  <= tx_p_data_d;
            rf_wr_en_q   <= rf_wr_en_d;
            rf_rd_en_q   <= rf_rd_en_d;
            tx_d_vld_q   <= tx_d_vld_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign bus.RF_ADDR    = rf_addr_q;
    assign bus.RF_WR_DATA = rf_wr_data_q;
    assign bus.RF_WR_EN   = rf_wr_en_q;
    assign bus.RF_RD_EN   = rf_rd_en_q;
    assign bus.TX_P_DATA  = tx_p_data_q;
    assign bus.TX_D_VLD   = tx_d_vld_q;
    assign bus.FRAME_ERR  = frame_err_q;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// -----------------------------------------------------------------------------
// tb_uart_cmd_decoder
//
// Directed bench for uart_cmd_decoder (TIMEOUT = 16). Inputs are driven on the
// falling edge, outputs are sampled on the falling edge; a monitor counts
// strobe and error pulses so each scenario can check exact pulse counts.
// -----------------------------------------------------------------------------
module tb_uart_cmd_decoder;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    uart_cmd_decoder_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    uart_cmd_decoder #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .TIMEOUT    (TO)
    ) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus.master)
    );

    int n_total = 0;
    int n_bad   = 0;

    int cyc = 0;
    int n_wr = 0, n_rd = 0, n_tx = 0, n_err = 0;
    int last_err_cyc = 0;
    int s_wr, s_rd, s_tx, s_err;
    int t_acc;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.RF_WR_EN)  n_wr  = n_wr + 1;
        if (bus.RF_RD_EN)  n_rd  = n_rd + 1;
        if (bus.TX_D_VLD)  n_tx  = n_tx + 1;
        if (bus.FRAME_ERR) begin
            n_err        = n_err + 1;
            last_err_cyc = cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // One byte, RX_D_VLD high for exactly one rising edge. Returns on the
    // falling edge right after the sampling edge.
    task automatic send(input logic [DW-1:0] b);
        @(negedge clk);
        bus.RX_P_DATA = b;
        bus.RX_D_VLD  = 1'b1;
        @(negedge clk);
        bus.RX_D_VLD  = 1'b0;
    endtask

    // Advance n falling edges and step past the monitor's update.
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic snap();
        #1;
        s_wr  = n_wr;
        s_rd  = n_rd;
        s_tx  = n_tx;
        s_err = n_err;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.RX_P_DATA      = '0;
        bus.RX_D_VLD       = 1'b0;
        bus.RF_RD_DATA     = '0;
        bus.RF_RD_DATA_VLD = 1'b0;
        bus.TX_BUSY        = 1'b0;

        // ---------------- reset state ----------------
        rst = 1'b1;
        tick(3);
        check("rst_rf_addr",    32'(bus.RF_ADDR),    0);
        check("rst_rf_wr_en",   32'(bus.RF_WR_EN),   0);
        check("rst_rf_rd_en",   32'(bus.RF_RD_EN),   0);
        check("rst_rf_wr_data", 32'(bus.RF_WR_DATA), 0);
        check("rst_tx_p_data",  32'(bus.TX_P_DATA),  0);
        check("rst_tx_d_vld",   32'(bus.TX_D_VLD),   0);
        check("rst_frame_err",  32'(bus.FRAME_ERR),  0);
        @(negedge clk);
        rst = 1'b0;

        // ---------------- basic write ----------------
        snap();
        send(8'hAA);
        send(8'h05);
        send(8'h3C);
        check("wr1_en",   32'(bus.RF_WR_EN),   1);
        check("wr1_addr", 32'(bus.RF_ADDR),    32'h5);
        check("wr1_data", 32'(bus.RF_WR_DATA), 32'h3C);
        tick(2);
        check("wr1_wr_cnt",  n_wr - s_wr,   1);
        check("wr1_rd_cnt",  n_rd - s_rd,   0);
        check("wr1_err_cnt", n_err - s_err, 0);

        // ---------------- read with busy transmitter ----------------
        bus.TX_BUSY = 1'b1;
        snap();
        send(8'hBB);
        send(8'h0F);
        check("rd1_en",   32'(bus.RF_RD_EN), 1);
        check("rd1_addr", 32'(bus.RF_ADDR),  32'hF);
        repeat (2) @(negedge clk);
        bus.RF_RD_DATA     = 8'h5A;
        bus.RF_RD_DATA_VLD = 1'b1;
        @(negedge clk);
        bus.RF_RD_DATA_VLD = 1'b0;
        bus.RF_RD_DATA     = 8'h00;
        tick(10);
        check("rd1_tx_held",   n_tx - s_tx,            0);
        check("rd1_tx_data_h", 32'(bus.TX_P_DATA),     32'h5A);
        bus.TX_BUSY = 1'b0;
        @(negedge clk);
        check("rd1_tx_vld",  32'(bus.TX_D_VLD),  1);
        check("rd1_tx_data", 32'(bus.TX_P_DATA), 32'h5A);
        tick(3);
        check("rd1_tx_cnt",  n_tx - s_tx,   1);
        check("rd1_rd_cnt",  n_rd - s_rd,   1);
        check("rd1_err_cnt", n_err - s_err, 0);

        // ---------------- stray byte and bad address ----------------
        snap();
        send(8'h11);
        check("err_stray", 32'(bus.FRAME_ERR), 1);
        send(8'hAA);
        send(8'h20);
        check("err_addr", 32'(bus.FRAME_ERR), 1);
        tick(2);
        check("err_cnt",    n_err - s_err, 2);
        check("err_wr_cnt", n_wr - s_wr,   0);
        check("err_rd_cnt", n_rd - s_rd,   0);

        // ---------------- timeout after command byte ----------------
        snap();
        send(8'hAA);
        t_acc = cyc;
        begin
            int w;
            w = 0;
            while (n_err == s_err && w < 40) begin
                @(negedge clk);
                #1;
                w++;
            end
        end
        check("to_err_cnt", n_err - s_err,        1);
        check("to_latency", last_err_cyc - t_acc, TO);
        tick(2);
        check("to_wr_cnt",  n_wr - s_wr,          0);
        send(8'hAA);
        send(8'h02);
        send(8'h77);
        check("to_wr_en",   32'(bus.RF_WR_EN),   1);
        check("to_wr_addr", 32'(bus.RF_ADDR),    32'h2);
        check("to_wr_data", 32'(bus.RF_WR_DATA), 32'h77);

        // ---------------- byte on the timeout cycle wins ----------------
        snap();
        send(8'hAA);
        repeat (TO - 2) @(negedge clk);
        send(8'h03);
        check("edge_no_err", 32'(bus.FRAME_ERR), 0);
        send(8'h99);
        check("edge_wr_en",   32'(bus.RF_WR_EN),   1);
        check("edge_wr_addr", 32'(bus.RF_ADDR),    32'h3);
        check("edge_wr_data", 32'(bus.RF_WR_DATA), 32'h99);
        tick(2);
        check("edge_err_cnt", n_err - s_err, 0);

        // ---------------- stray byte during read wait ----------------
        snap();
        send(8'hBB);
        send(8'h03);
        check("rd2_en", 32'(bus.RF_RD_EN), 1);
        // Coincident with RF_RD_EN: must be ignored.
        bus.RF_RD_DATA     = 8'hEE;
        bus.RF_RD_DATA_VLD = 1'b1;
        @(negedge clk);
        bus.RF_RD_DATA_VLD = 1'b0;
        send(8'h99);
        check("rd2_err", 32'(bus.FRAME_ERR), 1);
        @(negedge clk);
        bus.RF_RD_DATA     = 8'h33;
        bus.RF_RD_DATA_VLD = 1'b1;
        @(negedge clk);
        bus.RF_RD_DATA_VLD = 1'b0;
        @(negedge clk);
        check("rd2_tx_vld",  32'(bus.TX_D_VLD),  1);
        check("rd2_tx_data", 32'(bus.TX_P_DATA), 32'h33);
        tick(2);
        check("rd2_tx_cnt",  n_tx - s_tx,   1);
        check("rd2_err_cnt", n_err - s_err, 1);

        // ---------------- reset in the middle of a write ----------------
        snap();
        send(8'hAA);
        send(8'h04);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_addr", 32'(bus.RF_ADDR), 0);
        tick(4);
        check("rst_mid_wr_cnt",  n_wr - s_wr,   0);
        check("rst_mid_err_cnt", n_err - s_err, 0);
        send(8'hAA);
        send(8'h06);
        send(8'hC3);
        check("rst_wr_en",   32'(bus.RF_WR_EN),   1);
        check("rst_wr_addr", 32'(bus.RF_ADDR),    32'h6);
        check("rst_wr_data", 32'(bus.RF_WR_DATA), 32'hC3);
        tick(2);
        check("rst_wr_cnt", n_wr - s_wr, 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
